// File: rtl/display_pkg.sv
// Shared types and codes for the binary-to-BCD display path.
// BCD_BLANK is the nibble the 7-segment decoders show as all segments off.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } b2b_state_t;

  localparam logic [3:0] BCD_BLANK = 4'hF;

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Double-dabble digit correction.
// Adds 3 to a BCD nibble of 5 or more, ahead of the left shift.
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter, one shift per clock.
// Output formatting covers overflow blanking and optional leading-zero blanking.
module bin_to_bcd_seq
  import display_pkg::*;
#(
  parameter int BIN_W    = 14,
  parameter int DIGITS   = 4,
  parameter int BLANK_LZ = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  valid_in,
  output logic                  ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  valid_out,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int RW = BW + BIN_W;
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [31:0] MAX_VAL = 32'(10 ** DIGITS - 1);

  b2b_state_t      state_q;
  logic [RW-1:0]   sr_q;
  logic [RW-1:0]   sr_d;
  logic [CW-1:0]   cnt_q;
  logic            ovf_q;
  logic            ovf_out_q;
  logic            vout_q;
  logic            rdy_q;
  logic [BW-1:0]   bcd_q;
  logic [BW-1:0]   adj;
  logic [31:0]     bin_wide;
  logic            ovf_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d (sr_q[BIN_W+4*g +: 4]),
      .q (adj[4*g +: 4])
    );
  end

  assign sr_d     = {adj, sr_q[BIN_W-1:0]} << 1;
  assign bin_wide = 32'(bin_in);
  assign ovf_d    = bin_wide > MAX_VAL;

  function automatic logic [BW-1:0] fmt(
    input logic [BW-1:0] v,
    input logic          ovf
  );
    logic [BW-1:0] r;
    logic          lead;
    r    = v;
    lead = 1'b1;
    if (ovf) begin
      r = {DIGITS{BCD_BLANK}};
    end else if (BLANK_LZ != 0) begin
      for (int k = DIGITS - 1; k >= 1; k--) begin
        if (lead && v[4*k +: 4] == 4'd0) r[4*k +: 4] = BCD_BLANK;
        else lead = 1'b0;
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      ovf_out_q <= 1'b0;
      vout_q    <= 1'b0;
      rdy_q     <= 1'b1;
      bcd_q     <= {DIGITS{BCD_BLANK}};
    end else begin
      vout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            sr_q    <= {{BW{1'b0}}, bin_in};
            cnt_q   <= '0;
            ovf_q   <= ovf_d;
            rdy_q   <= 1'b0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          sr_q  <= sr_d;
          cnt_q <= cnt_q + 1'b1;
          // final shift publishes the formatted result
          if (cnt_q == CW'(BIN_W - 1)) begin
            bcd_q     <= fmt(sr_d[RW-1:BIN_W], ovf_q);
            ovf_out_q <= ovf_q;
            vout_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready     = rdy_q;
  assign bcd_out   = bcd_q;
  assign valid_out = vout_q;
  assign overflow  = ovf_out_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench: two converters, plain and leading-zero blanking.
// Stimulus pushes expected results; negedge monitors pop and compare.
module tb_bin_to_bcd_seq;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] bin_a = '0;
  logic [13:0] bin_b = '0;
  logic        vin_a = 1'b0;
  logic        vin_b = 1'b0;
  logic        rdy_a, rdy_b;
  logic [15:0] bcd_a, bcd_b;
  logic        vo_a, vo_b;
  logic        ovf_a, ovf_b;

  int   cyc = 0;
  int   npass = 0;
  int   ntot = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  logic pva = 1'b0;
  logic pvb = 1'b0;

  bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4), .BLANK_LZ(0)) u_a (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_a), .valid_in(vin_a),
    .ready(rdy_a), .bcd_out(bcd_a), .valid_out(vo_a), .overflow(ovf_a)
  );

  bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4), .BLANK_LZ(1)) u_b (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_b), .valid_in(vin_b),
    .ready(rdy_b), .bcd_out(bcd_b), .valid_out(vo_b), .overflow(ovf_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    ntot++;
    if (got === want) npass++;
    else $display("FAIL %s got=%0h want=%0h (cyc %0d)", nm, got, want, cyc);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (pva) chk("a_ready_after", 32'(rdy_a), 1);
      if (vo_a) begin
        if (qa.size() == 0) begin
          chk("a_spurious_valid", 1, 0);
        end else begin
          ea = qa.pop_front();
          chk("a_bcd", 32'(bcd_a), 32'(ea.bcd));
          chk("a_ovf", 32'(ovf_a), 32'(ea.ovf));
          chk("a_latency", 32'(cyc), 32'(ea.acc + 14));
          chk("a_ready_low", 32'(rdy_a), 0);
        end
      end
    end
    pva = vo_a && rst_n;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (pvb) chk("b_ready_after", 32'(rdy_b), 1);
      if (vo_b) begin
        if (qb.size() == 0) begin
          chk("b_spurious_valid", 1, 0);
        end else begin
          eb = qb.pop_front();
          chk("b_bcd", 32'(bcd_b), 32'(eb.bcd));
          chk("b_ovf", 32'(ovf_b), 32'(eb.ovf));
          chk("b_latency", 32'(cyc), 32'(eb.acc + 14));
        end
      end
    end
    pvb = vo_b && rst_n;
  end

  task automatic issue(bit on_b, logic [13:0] v, logic [15:0] want,
                       logic wovf, bit push);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!(on_b ? rdy_b : rdy_a) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("ready_timeout", 0, 1);
    e.bcd = want;
    e.ovf = wovf;
    e.acc = cyc + 1;
    if (on_b) begin
      bin_b = v;
      vin_b = 1'b1;
      if (push) qb.push_back(e);
    end else begin
      bin_a = v;
      vin_a = 1'b1;
      if (push) qa.push_back(e);
    end
    @(negedge clk);
    vin_a = 1'b0;
    vin_b = 1'b0;
    bin_a = 14'h2AAA;
    bin_b = 14'h1555;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("drain_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  localparam logic [13:0] SV_BIN [4] = '{14'd100, 14'd692, 14'd1284, 14'd1876};
  localparam logic [15:0] SV_BCD [4] = '{16'h0100, 16'h0692, 16'h1284, 16'h1876};

  initial begin
    exp_t e;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_bcd_async", 32'(bcd_a), 32'hFFFF);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_bcd_a", 32'(bcd_a), 32'hFFFF);
    chk("idle_rdy_a", 32'(rdy_a), 1);
    chk("idle_vo_a", 32'(vo_a), 0);
    chk("idle_ovf_a", 32'(ovf_a), 0);
    chk("idle_bcd_b", 32'(bcd_b), 32'hFFFF);
    chk("idle_rdy_b", 32'(rdy_b), 1);

    issue(0, 14'd1234, 16'h1234, 0, 1);
    drain();
    issue(0, 14'd9999, 16'h9999, 0, 1);
    issue(0, 14'd10000, 16'hFFFF, 1, 1);
    issue(0, 14'd42, 16'h0042, 0, 1);
    issue(0, 14'd0, 16'h0000, 0, 1);
    issue(0, 14'd16383, 16'hFFFF, 1, 1);
    drain();

    issue(1, 14'd7, 16'hFFF7, 0, 1);
    issue(1, 14'd0, 16'hFFF0, 0, 1);
    issue(1, 14'd305, 16'hF305, 0, 1);
    issue(1, 14'd1000, 16'h1000, 0, 1);
    issue(1, 14'd10000, 16'hFFFF, 1, 1);
    issue(1, 14'd9009, 16'h9009, 0, 1);
    drain();

    // valid held high while bin_in moves every cycle
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      vin_a = 1'b1;
      bin_a = 14'(100 + 37 * k);
      if (k % 16 == 0) begin
        e.bcd = SV_BCD[k / 16];
        e.ovf = 1'b0;
        e.acc = cyc + 1;
        qa.push_back(e);
        chk("stream_vec", 32'(bin_a), 32'(SV_BIN[k / 16]));
      end
    end
    @(negedge clk);
    vin_a = 1'b0;
    drain();

    issue(0, 14'd4321, 16'h4321, 0, 0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_bcd", 32'(bcd_a), 32'hFFFF);
    chk("abort_vo", 32'(vo_a), 0);
    chk("abort_rdy", 32'(rdy_a), 1);
    chk("abort_ovf", 32'(ovf_a), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_abort_bcd", 32'(bcd_a), 32'hFFFF);
    issue(0, 14'd56, 16'h0056, 0, 1);
    drain();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
